// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type and length-field width helper for the sequence detector
package seq_det_pkg;
  typedef enum logic {IDLE, ARMED} state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_det_hist.sv
// seq_det_hist: serial history shift register plus saturating fill counter; exposes post-shift values for same-cycle hit detection
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               ip,
  output logic [MAX_LEN-1:0] hist_upd,
  output logic [LEN_W-1:0]   fill_upd
);
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  // clear wins over shift so a non-overlap hit restarts the fill from zero
  always_comb begin
    hist_upd = (hist_q << 1) | MAX_LEN'(ip);
    fill_upd = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    hist_d = clr ? '0 : shift ? hist_upd : hist_q;
    fill_d = clr ? '0 : shift ? fill_upd : fill_q;
  end
  // history and fill registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: programmable serial pattern detector (overlap/non-overlap); SEQ_DET_CNT_EN enables the detection counter
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ip,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  output logic               seq_det,
  output logic               armed,
  output logic [CNT_W-1:0]   det_cnt
);
  state_t state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, hist_upd, mask;
  logic [LEN_W-1:0] len_q, len_d, fill_upd;
  logic ovl_q, ovl_d, seq_det_q, seq_det_d, cfg_ok, shift, hit, clr;
  seq_det_hist #(.MAX_LEN(MAX_LEN)) u_hist (
    .clk(clk), .rst(rst), .clr(clr), .shift(shift), .ip(ip),
    .hist_upd(hist_upd), .fill_upd(fill_upd)
  );
  // load has priority over data; a hit compares only the low len bits of the shifted history
  always_comb begin
    cfg_ok = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
    shift = state_q == ARMED && en && !cfg_load;
    mask = {MAX_LEN{1'b1}} >> (LEN_W'(MAX_LEN) - len_q);
    hit = shift && ((hist_upd ^ pat_q) & mask) == '0 && fill_upd >= len_q;
    clr = cfg_load || (hit && !ovl_q);
    state_d = cfg_load ? (cfg_ok ? ARMED : IDLE) : state_q;
    pat_d = (cfg_load && cfg_ok) ? cfg_pat : pat_q;
    len_d = (cfg_load && cfg_ok) ? cfg_len : len_q;
    ovl_d = (cfg_load && cfg_ok) ? cfg_ovl : ovl_q;
    seq_det_d = hit;
  end
  // state, configuration and registered detection pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      seq_det_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      seq_det_q <= seq_det_d;
    end
  assign seq_det = seq_det_q;
  assign armed = state_q == ARMED;
`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // detection counter cleared by any load, saturating at all-ones
  always_comb cnt_d = cfg_load ? '0 : (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign det_cnt = cnt_q;
`else
  assign det_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed self-checking bench for seq_det_prog (default and CNT_W=2 instances)
module tb_seq_det_prog;
  localparam int MAX_LEN = 8;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  logic clk = 1'b0, rst, en, ip, cfg_load, cfg_ovl;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic seq_det, armed, sat_det, sat_armed;
  logic [7:0] det_cnt;
  logic [1:0] sat_cnt;
  int checks = 0, failures = 0;

  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .ip(ip), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .seq_det(seq_det), .armed(armed), .det_cnt(det_cnt)
  );
  seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .ip(ip), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
    .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .seq_det(sat_det), .armed(sat_armed), .det_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input int n, input int w);
    int mx = (1 << w) - 1;
    return CNT_ON ? (n > mx ? mx : n) : 0;
  endfunction

  task automatic load(input logic [7:0] pat, input int len, input logic ovl, input logic e, input logic b);
    cfg_load = 1'b1; cfg_pat = pat; cfg_len = LEN_W'(len); cfg_ovl = ovl; en = e; ip = b;
    @(posedge clk); #1;
    cfg_load = 1'b0; en = 1'b0;
  endtask

  task automatic feed(input string tag, input int n, input logic [15:0] bits, input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      en = 1'b1; ip = bits[i];
      @(posedge clk); #1;
      en = 1'b0;
      check(tag, seq_det, exp[i]);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b0; ip = 1'b1;
      @(posedge clk); #1;
      check(tag, seq_det, 0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ip = 1'b0; cfg_load = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_armed", armed, 0);
    check("rst_det", seq_det, 0);
    check("rst_cnt", det_cnt, 0);
    #2 rst = 1'b0;

    load(8'b00011101, 5, 1'b1, 1'b0, 1'b0);
    check("ovl5_armed", armed, 1);
    feed("ovl5", 9, 16'b111011101, 16'b000010001);
    check("ovl5_cnt", det_cnt, exp_cnt(2, 8));
    check("ovl5_sat_cnt", sat_cnt, exp_cnt(2, 2));

    load(8'b00001101, 4, 1'b1, 1'b0, 1'b0);
    feed("ovl4", 7, 16'b1101101, 16'b0001001);
    check("ovl4_cnt", det_cnt, exp_cnt(2, 8));
    load(8'b00001101, 4, 1'b0, 1'b0, 1'b0);
    feed("novl4", 7, 16'b1101101, 16'b0001000);
    check("novl4_cnt", det_cnt, exp_cnt(1, 8));

    load(8'b00001101, 4, 1'b0, 1'b0, 1'b0);
    feed("gap_a", 2, 16'b11, 16'b00);
    idle("gap_idle", 3);
    feed("gap_b", 2, 16'b01, 16'b01);
    idle("gap_drop", 1);
    check("gap_cnt", det_cnt, exp_cnt(1, 8));
    load(8'b00001101, 4, 1'b0, 1'b1, 1'b1);
    check("prio_det", seq_det, 0);
    check("prio_cnt", det_cnt, 0);
    feed("prio", 4, 16'b1011, 16'b0000);

    load(8'b00001101, 0, 1'b1, 1'b0, 1'b0);
    check("len0_armed", armed, 0);
    feed("len0", 4, 16'b1101, 16'b0000);
    check("len0_cnt", det_cnt, 0);
    load(8'b00001101, 4, 1'b1, 1'b0, 1'b0);
    check("relo_armed", armed, 1);
    load(8'b00001101, 9, 1'b1, 1'b0, 1'b0);
    check("len9_armed", armed, 0);

    load(8'hFF, MAX_LEN, 1'b1, 1'b0, 1'b0);
    feed("maxlen", 9, 16'h1FF, 16'b000000011);
    check("maxlen_cnt", det_cnt, exp_cnt(2, 8));

    load(8'b00000001, 1, 1'b1, 1'b0, 1'b0);
    feed("sat", 5, 16'b11111, 16'b11111);
    check("sat_cnt2", sat_cnt, exp_cnt(5, 2));
    check("sat_cnt8", det_cnt, exp_cnt(5, 8));

    load(8'b00001101, 4, 1'b1, 1'b0, 1'b0);
    feed("mrst_pre", 3, 16'b110, 16'b000);
    en = 1'b1; ip = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mrst_armed_now", armed, 0);
    check("mrst_det_now", seq_det, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    check("mrst_det", seq_det, 0);
    check("mrst_armed", armed, 0);
    feed("mrst_idle", 4, 16'b1101, 16'b0000);
    check("mrst_still_idle", armed, 0);
    check("mrst_cnt", det_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_det_prog.md
SEQ_DET_PROG -- requirements
Module: seq_det_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning the longest detectable pattern in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the detection counter.
REQ-003 SHALL define LEN_W = $clog2(MAX_LEN+1), used for length fields.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit: ip is valid this cycle.
REQ-007 SHALL have port ip, input, 1 bit: serial data bit.
REQ-008 SHALL have port cfg_load, input, 1 bit: latch the configuration this cycle.
REQ-009 SHALL have port cfg_pat, input, MAX_LEN bits: pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-010 SHALL have port cfg_len, input, LEN_W bits: pattern length.
REQ-011 SHALL have port cfg_ovl, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-012 SHALL have port seq_det, output, 1 bit: registered one-cycle detection pulse.
REQ-013 SHALL have port armed, output, 1 bit: a valid configuration is active.
REQ-014 SHALL have port det_cnt, output, CNT_W bits: detections since the last load.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and ARMED.
REQ-016 In IDLE, SHALL ignore en and ip, and hold seq_det at 0.
REQ-017 On cfg_load with 1 <= cfg_len <= MAX_LEN, SHALL latch pat, len and ovl, clear the history, fill count and det_cnt, and enter ARMED on the next edge.
REQ-018 On cfg_load with cfg_len = 0 or cfg_len > MAX_LEN, SHALL enter IDLE and clear det_cnt.
REQ-019 A cfg_load SHALL be accepted in any state; when cfg_load and en are both high in the same cycle, the load takes priority and that ip bit is discarded.
REQ-020 In ARMED with en=1, SHALL shift ip into the history LSB and increment the fill count, saturating at MAX_LEN.
REQ-021 A hit SHALL be defined as: the updated history[len-1:0] equals pat[len-1:0] and the updated fill >= len.
REQ-022 On a hit, SHALL assert seq_det for exactly the one cycle after the edge that sampled the final pattern bit (Moore-style, latency 1).
REQ-023 On a hit with ovl=1, SHALL keep the fill count, so that suffix/prefix overlap is detectable.
REQ-024 On a hit with ovl=0, SHALL reset the fill count to 0, so that no bit is reused.
REQ-025 In ARMED with en=0, SHALL hold the history, the fill count and det_cnt, and drive seq_det to 0 in the next cycle.
REQ-026 On each hit, det_cnt SHALL increment, saturating at 2^CNT_W-1 (no wrap).
REQ-027 armed SHALL be 1 exactly when the state is ARMED.

Reset
REQ-028 While rst is high, SHALL hold state=IDLE, history=0, fill=0, seq_det=0, armed=0, det_cnt=0, and the configuration registers at 0.
REQ-029 A reset asserted mid-stream SHALL discard partial matches; after release, the block SHALL stay in IDLE until a valid cfg_load.

Configuration
REQ-030 Macro SEQ_DET_CNT_EN: when defined, det_cnt SHALL behave as specified in REQ-026.
REQ-031 When SEQ_DET_CNT_EN is undefined, SHALL keep the det_cnt port, drive it constant 0, and synthesize no counter logic.

Structure
REQ-032 Package seq_det_pkg SHALL hold the FSM state typedef (IDLE, ARMED) and the LEN_W helper function.
REQ-033 Sub-module seq_det_hist SHALL hold the history shift register and the saturating fill counter, with a clear input driven by load and by non-overlap hits.

Verification
REQ-034 Overlap test: pattern 11101 (cfg_pat=5'b11101, len=5, ovl=1), stream 1,1,1,0,1,1,1,0,1 -> seq_det pulses after bits 5 and 9; det_cnt=2.
REQ-035 Overlap vs non-overlap test: pattern 1101 (len=4), stream 1,1,0,1,1,0,1 -> ovl=1 gives hits after bits 4 and 7; ovl=0 gives a hit after bit 4 only.
REQ-036 Gaps and load priority test: en deasserted for 3 cycles mid-pattern -> match still completes; cfg_load together with en -> that bit is dropped and det_cnt=0.
REQ-037 Invalid length and max length test: cfg_len=0 -> armed=0 and no pulses; cfg_len=MAX_LEN with an all-ones pattern -> first hit after exactly MAX_LEN ones.
REQ-038 Saturation test: with CNT_W=2 and 5 hits -> det_cnt=3; with SEQ_DET_CNT_EN undefined -> det_cnt=0 throughout.
REQ-039 Mid-stream reset test: rst pulsed asynchronously (between clock edges) one bit before a hit completes -> no seq_det pulse, armed=0 immediately.
